seq_chain_monitor: RTL and testbench
====================================

# seq_chain_monitor

Synthesizable, parametrised checker for an N-step implication chain `step[0] |=> step[1] |=> ... |=> step[N-1]`. It tracks every overlapping attempt in hardware, reports pass, fail and vacuous outcomes, and keeps saturating statistics counters. It sits beside a DUT in the assertion-support library and gives FPGA/emulation and formal-lite runs the same pass/fail/cover visibility that simulator-only assertions provide. Two checking modes are selectable: nested-implication and strict-sequence.

## Interface
- `STEPS`, default 3: chain length, legal range 2..16.
- `CNT_W`, default 16: width of every statistics counter, legal range 2..32.
- `STRICT`, default 0:
  - 0 = nested implication; an intermediate miss is vacuous.
  - 1 = `step[0] |=> step[1] ##1 ... ##1 step[N-1]`; any miss fails.
- `clk` in 1: sole clock; everything samples on its rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: when 1, a sampled `step_i[0]` starts an attempt.
- `step_i` in STEPS: `step_i[k]` is the k-th chain expression.
- `pass_o` out 1: one-cycle pulse when an attempt completes all steps.
- `fail_o` out 1: one-cycle pulse when at least one attempt fails this cycle.
- `vac_o` out 1: one-cycle pulse when an attempt ends vacuously (STRICT=0 only).
- `error_o` out 1: sticky; set on the first fail, cleared only by `reset`.
- `fail_stage_o` out 4: step index of the first failure; valid while `error_o`=1.
- `busy_o` out 1: 1 while any attempt is in flight.
- `attempt_cnt`, `pass_cnt`, `fail_cnt`, `vac_cnt` out CNT_W each: saturating counts.
- `cov_cnt` out CNT_W: count of `step[0] ##1 step[1]` matches (see Configuration).

## Operation
- The in-flight state is a vector `pend[STEPS-1:1]`:
  - `pend[k]`=1 means an attempt expects `step_i[k]` at the current edge.
  - Each stage holds at most one attempt, because attempts start on distinct edges. No queue is needed.
- Evaluation per edge, for each stage k:
  - **Start:** if `en && step_i[0]`, set `pend_next[1]` and increment `attempt_cnt`.
  - **Advance:** `pend[k] && step_i[k]` with k < STEPS-1 sets `pend_next[k+1]`.
  - **Pass:** `pend[STEPS-1] && step_i[STEPS-1]` produces a pass.
  - **Miss, STRICT=1:** `pend[k] && !step_i[k]` is a fail at stage k.
  - **Miss, STRICT=0, k < STEPS-1:** vacuous.
  - **Miss, STRICT=0, k = STEPS-1:** fail.
- Several stages can fail on the same edge (STRICT=1):
  - `fail_o` pulses once.
  - `fail_cnt` adds the popcount, saturating.
  - `fail_stage_o` captures the lowest failing k, only if `error_o` was 0.
- Several vacuous stages on the same edge: `vac_o` pulses once and `vac_cnt` adds the popcount.
- Pass and fail (or pass and vacuous) can occur on the same edge; both pulses assert.
- `en`=0 blocks only new starts. Attempts already in flight run to completion.
- All counters saturate at 2^CNT_W-1 and never wrap.
- `busy_o` = |pend.

## Timing
- An attempt starts at edge T0 when `step_i[0]`=1 is sampled there.
- `step_i[k]` is sampled at edge T0+k.
- Pulses and counter updates are registered at the deciding edge and are visible in the following cycle. Pulse width is exactly one cycle.
- A pass has a latency of STEPS-1 edges after the start edge.
- On `reset`=1 at an edge:
  - `pend`, all pulses, `error_o`, `fail_stage_o` and all counters become 0.
  - `busy_o` becomes 0.
  - In-flight attempts are discarded with no outcome reported.
- `step_i[0]` sampled at the same edge where `reset`=1 does not start an attempt.

## Configuration
- `SEQ_MON_COVER_EN` defined:
  - Adds a prefix-cover tracker: a registered `step_i[0]` ANDed with the current `step_i[1]`, independent of `en` and `STRICT`.
  - `cov_cnt` increments (saturating) on each match.
- `SEQ_MON_COVER_EN` undefined: no tracker logic; `cov_cnt` is tied to 0. The port list is identical either way.

## Test plan
All scenarios use STEPS=3 and CNT_W=16 unless stated.
1. STRICT=0; `step_i[0]`=1 at edge 0, `step_i[1]`=1 at edge 1, `step_i[2]`=1 at edge 2 -> `pass_o` pulses after edge 2; `pass_cnt`=1, `attempt_cnt`=1, `busy_o` 0 after edge 2.
2. Start at edge 0, `step_i[1]`=0 at edge 1:
   - STRICT=0 -> `vac_o` pulse, `fail_cnt`=0, `error_o`=0.
   - STRICT=1 -> `fail_o` pulse, `fail_cnt`=1, `error_o`=1, `fail_stage_o`=1.
3. Overlap: `step_i`=3'b111 held for edges 0..4 -> passes after edges 2, 3 and 4; `pass_cnt`=3, `attempt_cnt`=5, `busy_o`=1 after edge 4.
4. STRICT=1; starts at edges 0 and 1, `step_i[1]`=0 at edge 2, `step_i[2]`=0 at edge 2 -> single `fail_o` pulse, `fail_cnt`=2, `fail_stage_o`=1.
5. CNT_W=4; 20 consecutive starts with all steps true -> `attempt_cnt` stops at 15 and `pass_cnt` stops at 15; then `reset`=1 at edge 1 of a new attempt -> all outputs are 0 next cycle and no late `pass_o` pulse appears.
6. With `SEQ_MON_COVER_EN`, `en`=0; `step_i[0]` at edge 0, `step_i[1]` at edge 1 -> `cov_cnt`=1, `attempt_cnt`=0. Without the macro, `cov_cnt`=0.

Source files
------------

// File: rtl/seq_chain_monitor.sv
// Hardware checker for the implication chain step[0] |=> step[1] |=> ... |=> step[STEPS-1].
// Build option: define SEQ_MON_COVER_EN to count step[0] ##1 step[1] prefix matches.
module seq_chain_monitor #(
   parameter int STEPS  = 3,
   parameter int CNT_W  = 16,
   parameter int STRICT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [STEPS-1:0] step_i,
   output logic             pass_o,
   output logic             fail_o,
   output logic             vac_o,
   output logic             error_o,
   output logic [3:0]       fail_stage_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] attempt_cnt,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] vac_cnt,
   output logic [CNT_W-1:0] cov_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [STEPS-1:1] LAST_M  = (STEPS-1)'(1) << (STEPS-2);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [4:0] inc);
      logic [CNT_W+4:0] s;
      s = {5'd0, a} + {{CNT_W{1'b0}}, inc};
      if (s > {5'd0, CNT_MAX})
         return CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   function automatic logic [4:0] popcnt(input logic [STEPS-1:1] v);
      logic [4:0] c;
      c = '0;
      for (int k = 1; k < STEPS; k++)
         c = c + 5'(v[k]);
      return c;
   endfunction

   // pend[k]: an attempt expects step_i[k] at this edge
   logic [STEPS-1:1] pend;
   logic [STEPS-1:1] pend_nxt;
   logic [STEPS-1:1] hit;
   logic [STEPS-1:1] miss;
   logic [STEPS-1:1] fail_vec;
   logic [STEPS-1:1] vac_vec;
   logic             start;
   logic             pass_c;
   logic [3:0]       low_k;

   assign start    = en & step_i[0];
   assign hit      = pend & step_i[STEPS-1:1];
   assign miss     = pend & ~step_i[STEPS-1:1];
   // Nested implication only fails at the final step; earlier misses are vacuous
   assign fail_vec = (STRICT != 0) ? miss : (miss & LAST_M);
   assign vac_vec  = (STRICT != 0) ? '0 : (miss & ~LAST_M);
   assign pend_nxt = (STEPS-1)'({hit, start});
   assign pass_c   = hit[STEPS-1];
   assign busy_o   = |pend;

   always_comb begin
      low_k = '0;
      for (int k = STEPS-1; k >= 1; k--)
         if (fail_vec[k])
            low_k = 4'(k);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend         <= '0;
         pass_o       <= 1'b0;
         fail_o       <= 1'b0;
         vac_o        <= 1'b0;
         error_o      <= 1'b0;
         fail_stage_o <= '0;
         attempt_cnt  <= '0;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         vac_cnt      <= '0;
      end else begin
         pend        <= pend_nxt;
         pass_o      <= pass_c;
         fail_o      <= |fail_vec;
         vac_o       <= |vac_vec;
         attempt_cnt <= sat_add(attempt_cnt, 5'(start));
         pass_cnt    <= sat_add(pass_cnt, 5'(pass_c));
         fail_cnt    <= sat_add(fail_cnt, popcnt(fail_vec));
         vac_cnt     <= sat_add(vac_cnt, popcnt(vac_vec));
         if ((|fail_vec) && !error_o) begin
            error_o      <= 1'b1;
            fail_stage_o <= low_k;
         end
      end
   end

`ifdef SEQ_MON_COVER_EN
   // Prefix cover ignores en and STRICT
   logic step0_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         step0_p1 <= 1'b0;
         cov_cnt  <= '0;
      end else begin
         step0_p1 <= step_i[0];
         cov_cnt  <= sat_add(cov_cnt, 5'(step0_p1 & step_i[1]));
      end
   end
`else
   assign cov_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_chain_monitor.sv
// Directed bench: three monitor instances (nested, strict, 4-bit counters) share one stimulus.
module tb_seq_chain_monitor;

   logic       clk;
   logic       reset;
   logic       en;
   logic [2:0] step_i;

   logic        a_pass, a_fail, a_vac, a_err, a_busy;
   logic [3:0]  a_stage;
   logic [15:0] a_att, a_pcnt, a_fcnt, a_vcnt, a_cov;

   logic        b_pass, b_fail, b_vac, b_err, b_busy;
   logic [3:0]  b_stage;
   logic [15:0] b_att, b_pcnt, b_fcnt, b_vcnt, b_cov;

   logic        c_pass, c_fail, c_vac, c_err, c_busy;
   logic [3:0]  c_stage;
   logic [3:0]  c_att, c_pcnt, c_fcnt, c_vcnt, c_cov;

   int checks = 0;
   int errors = 0;

   seq_chain_monitor #(.STEPS(3), .CNT_W(16), .STRICT(0)) u_nest (
      .clk(clk), .reset(reset), .en(en), .step_i(step_i),
      .pass_o(a_pass), .fail_o(a_fail), .vac_o(a_vac), .error_o(a_err),
      .fail_stage_o(a_stage), .busy_o(a_busy), .attempt_cnt(a_att),
      .pass_cnt(a_pcnt), .fail_cnt(a_fcnt), .vac_cnt(a_vcnt), .cov_cnt(a_cov)
   );

   seq_chain_monitor #(.STEPS(3), .CNT_W(16), .STRICT(1)) u_strict (
      .clk(clk), .reset(reset), .en(en), .step_i(step_i),
      .pass_o(b_pass), .fail_o(b_fail), .vac_o(b_vac), .error_o(b_err),
      .fail_stage_o(b_stage), .busy_o(b_busy), .attempt_cnt(b_att),
      .pass_cnt(b_pcnt), .fail_cnt(b_fcnt), .vac_cnt(b_vcnt), .cov_cnt(b_cov)
   );

   seq_chain_monitor #(.STEPS(3), .CNT_W(4), .STRICT(0)) u_small (
      .clk(clk), .reset(reset), .en(en), .step_i(step_i),
      .pass_o(c_pass), .fail_o(c_fail), .vac_o(c_vac), .error_o(c_err),
      .fail_stage_o(c_stage), .busy_o(c_busy), .attempt_cnt(c_att),
      .pass_cnt(c_pcnt), .fail_cnt(c_fcnt), .vac_cnt(c_vcnt), .cov_cnt(c_cov)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [2:0] s);
      step_i = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      en     = 1'b1;
      step_i = 3'b000;
      tick(3'b001);
      tick(3'b001);
      reset = 1'b0;
      chk("rst_busy", a_busy, 0);
      chk("rst_att", a_att, 0);
      chk("rst_err", b_err, 0);
      chk("rst_pass", a_pass, 0);
      chk("rst_stage", b_stage, 0);

      // Test 1: single passing attempt
      tick(3'b001);
      chk("t1_busy_e0", a_busy, 1);
      chk("t1_pass_e0", a_pass, 0);
      tick(3'b010);
      chk("t1_pass_e1", a_pass, 0);
      tick(3'b100);
      chk("t1_pass_a", a_pass, 1);
      chk("t1_pass_b", b_pass, 1);
      chk("t1_pcnt", a_pcnt, 1);
      chk("t1_att", a_att, 1);
      chk("t1_busy", a_busy, 0);
      tick(3'b000);
      chk("t1_pulse_w", a_pass, 0);

      // Test 2: intermediate miss
      tick(3'b001);
      tick(3'b000);
      chk("t2_vac_a", a_vac, 1);
      chk("t2_fcnt_a", a_fcnt, 0);
      chk("t2_err_a", a_err, 0);
      chk("t2_vcnt_a", a_vcnt, 1);
      chk("t2_fail_b", b_fail, 1);
      chk("t2_vac_b", b_vac, 0);
      chk("t2_fcnt_b", b_fcnt, 1);
      chk("t2_err_b", b_err, 1);
      chk("t2_stage_b", b_stage, 1);
      chk("t2_att", b_att, 2);
      tick(3'b000);
      chk("t2_vac_w", a_vac, 0);
      chk("t2_fail_w", b_fail, 0);
      chk("t2_err_sticky", b_err, 1);

      // Test 4: two stages miss on the same edge
      reset = 1'b1;
      tick(3'b000);
      reset = 1'b0;
      tick(3'b001);
      tick(3'b011);
      tick(3'b000);
      chk("t4_fail_b", b_fail, 1);
      chk("t4_fcnt_b", b_fcnt, 2);
      chk("t4_stage_b", b_stage, 1);
      chk("t4_fail_a", a_fail, 1);
      chk("t4_vac_a", a_vac, 1);
      chk("t4_fcnt_a", a_fcnt, 1);
      chk("t4_stage_a", a_stage, 2);
      tick(3'b000);
      chk("t4_fail_w", b_fail, 0);

      // Test 3: overlapping attempts, then en=0 drains in-flight attempts
      reset = 1'b1;
      tick(3'b000);
      reset = 1'b0;
      tick(3'b111);
      tick(3'b111);
      chk("t3_pass_e1", a_pass, 0);
      tick(3'b111);
      chk("t3_pass_e2", a_pass, 1);
      tick(3'b111);
      chk("t3_pass_e3", a_pass, 1);
      tick(3'b111);
      chk("t3_pass_e4", a_pass, 1);
      chk("t3_pcnt", a_pcnt, 3);
      chk("t3_att", a_att, 5);
      chk("t3_busy", a_busy, 1);
      chk("t3_err_b", b_err, 0);
      en = 1'b0;
      tick(3'b111);
      tick(3'b111);
      chk("t3_drain_pcnt", a_pcnt, 5);
      chk("t3_drain_att", a_att, 5);
      chk("t3_drain_busy", a_busy, 0);
      en = 1'b1;

      // Test 6: prefix cover with en=0
      reset = 1'b1;
      tick(3'b000);
      reset = 1'b0;
      en = 1'b0;
      tick(3'b001);
      tick(3'b010);
      chk("t6_att", a_att, 0);
`ifdef SEQ_MON_COVER_EN
      chk("t6_cov", a_cov, 1);
`else
      chk("t6_cov", a_cov, 0);
`endif
      en = 1'b1;

      // Test 5: counter saturation, then reset discards an in-flight attempt
      reset = 1'b1;
      tick(3'b000);
      reset = 1'b0;
      for (int i = 0; i < 20; i++)
         tick(3'b111);
      chk("t5_att_sat", c_att, 15);
      chk("t5_pcnt_sat", c_pcnt, 15);
      chk("t5_att_wide", a_att, 20);
      chk("t5_pcnt_wide", a_pcnt, 18);
      tick(3'b110);
      tick(3'b110);
      chk("t5_pcnt_hold", c_pcnt, 15);
      chk("t5_pcnt_wide2", a_pcnt, 20);
      chk("t5_idle", c_busy, 0);
      tick(3'b001);
      chk("t5_busy", c_busy, 1);
      reset = 1'b1;
      tick(3'b010);
      reset = 1'b0;
      chk("t5_rst_att", c_att, 0);
      chk("t5_rst_pcnt", c_pcnt, 0);
      chk("t5_rst_busy", c_busy, 0);
      chk("t5_rst_pass", c_pass, 0);
      tick(3'b100);
      chk("t5_no_late_pass", c_pass, 0);
      chk("t5_no_late_pcnt", c_pcnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
